// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline interlock controller for a 5-stage in-order core. Generates the
// per-stage hold signals, the IF/ID flush and the ID/EXE bubble from a small
// registered FSM (RUN, DMEM_WAIT, IMEM_WAIT, FLUSH) plus the current inputs.
// Priority: dmem wait > branch flush > imem wait > load-use hazard.
// Stalls always cover a prefix of the pipe: a later stage never holds unless
// every earlier stage holds too.
//
// Optional feature macro: STALL_PERF_CNT_EN
//   defined   -> stall_cycles counts cycles with if_id_stall=1, saturating
//   undefined -> stall_cycles is tied to zero and no counter is built
// -----------------------------------------------------------------------------
module hazard_stall_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  id_sr1,
   input  logic [2:0]  id_sr2,
   input  logic        id_sr1_used,
   input  logic        id_sr2_used,
   input  logic [2:0]  ex_dr,
   input  logic        ex_load,
   input  logic        ex_valid,
   input  logic        imem_read,
   input  logic        imem_resp,
   input  logic        dmem_req,
   input  logic        dmem_resp,
   input  logic        br_taken,
   output logic        if_id_stall,
   output logic        id_exe_stall,
   output logic        exe_mem_stall,
   output logic        mem_wb_stall,
   output logic        if_id_flush,
   output logic        id_exe_bubble,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_DMEM_WAIT = 2'd1,
      ST_IMEM_WAIT = 2'd2,
      ST_FLUSH     = 2'd3
   } state_t;

   state_t      r_state;
   logic [1:0]  r_flush_cnt;   // flush cycles still owed while in FLUSH
   logic        r_br_pend;     // branch seen while the data memory held the pipe

   logic        w_hazard;
   logic        w_dmem_wait;
   logic        w_imem_wait;
   logic        w_flush_now;

   // Load-use: EX holds a real load whose destination is read by ID.
   assign w_hazard = ex_valid & ex_load &
                     ((id_sr1_used & (id_sr1 == ex_dr)) |
                      (id_sr2_used & (id_sr2 == ex_dr)));

   assign w_dmem_wait = dmem_req & ~dmem_resp;
   assign w_imem_wait = imem_read & ~imem_resp;

   // A branch outside DMEM_WAIT flushes in its own cycle; FLUSH covers the rest.
   assign w_flush_now = (r_state == ST_FLUSH) |
                        (br_taken & (r_state != ST_DMEM_WAIT));

   // Combinational stall/flush/bubble decode in priority order, gated by reset.
   always_comb begin
      if_id_stall   = 1'b0;
      id_exe_stall  = 1'b0;
      exe_mem_stall = 1'b0;
      mem_wb_stall  = 1'b0;
      if_id_flush   = 1'b0;
      id_exe_bubble = 1'b0;
      if (!rst_n) begin
         if_id_stall   = 1'b0;
      end else if (w_dmem_wait) begin
         // Data memory not ready: freeze the whole pipe.
         if_id_stall   = 1'b1;
         id_exe_stall  = 1'b1;
         exe_mem_stall = 1'b1;
         mem_wb_stall  = 1'b1;
      end else if (r_state == ST_DMEM_WAIT) begin
         // Response cycle: the pipe advances, nothing held.
         if_id_stall   = 1'b0;
      end else if (w_flush_now) begin
         if_id_flush   = 1'b1;
         id_exe_bubble = 1'b1;
      end else if (w_imem_wait || w_hazard) begin
         // Hold fetch/decode, let downstream drain behind a bubble.
         if_id_stall   = 1'b1;
         id_exe_bubble = 1'b1;
      end else begin
         if_id_stall   = 1'b0;
      end
   end

   // Controller state, flush countdown and pending-branch flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= 2'd0;
         r_br_pend   <= 1'b0;
      end else begin
         case (r_state)
            ST_DMEM_WAIT: begin
               if (w_dmem_wait) begin
                  r_state <= ST_DMEM_WAIT;
                  if (br_taken) begin
                     r_br_pend <= 1'b1;
                  end else begin
                     r_br_pend <= r_br_pend;
                  end
               end else if (r_br_pend || br_taken) begin
                  // Full two-cycle flush starts after the response cycle.
                  r_state     <= ST_FLUSH;
                  r_flush_cnt <= 2'd2;
                  r_br_pend   <= 1'b0;
               end else if (r_flush_cnt != 2'd0) begin
                  // Resume a flush that the data wait interrupted.
                  r_state <= ST_FLUSH;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN, ST_IMEM_WAIT, ST_FLUSH: begin
               if (w_dmem_wait) begin
                  // Remaining flush count is kept and replayed afterwards.
                  r_state <= ST_DMEM_WAIT;
                  if (br_taken) begin
                     r_br_pend <= 1'b1;
                  end else begin
                     r_br_pend <= r_br_pend;
                  end
               end else if (br_taken) begin
                  r_state     <= ST_FLUSH;
                  r_flush_cnt <= 2'd1;
               end else if (r_state == ST_FLUSH) begin
                  r_flush_cnt <= r_flush_cnt - 2'd1;
                  if (r_flush_cnt <= 2'd1) begin
                     r_state     <= ST_RUN;
                     r_flush_cnt <= 2'd0;
                  end else begin
                     r_state <= ST_FLUSH;
                  end
               end else if (w_imem_wait) begin
                  r_state <= ST_IMEM_WAIT;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state     <= ST_RUN;
               r_flush_cnt <= 2'd0;
               r_br_pend   <= 1'b0;
            end
         endcase
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [15:0] r_stall_cycles;

   // Saturating count of cycles in which fetch/decode was held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= 16'h0000;
      end else if (if_id_stall && (r_stall_cycles != 16'hFFFF)) begin
         r_stall_cycles <= r_stall_cycles + 16'h0001;
      end else begin
         r_stall_cycles <= r_stall_cycles;
      end
   end

   assign stall_cycles = r_stall_cycles;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have ports: clk (in, 1, rising-edge clock); rst_n (in, 1, reset; asynchronous, active-low).
REQ-002 SHALL have inputs: id_sr1, id_sr2 (3 each, ID-stage source regs); id_sr1_used, id_sr2_used (1 each, source actually read).
REQ-003 SHALL have inputs: ex_dr (3, EX-stage dest reg); ex_load (1, EX instr is LDR/LDB/LDI); ex_valid (1, EX holds a real instr, not bubble).
REQ-004 SHALL have inputs: imem_read, imem_resp (1 each, fetch request/ack); dmem_req, dmem_resp (1 each, MEM-stage request/ack); br_taken (1, EX/MEM resolved taken branch/jump).
REQ-005 SHALL have outputs: if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall (1 each, hold the named pipeline register).
REQ-006 SHALL have outputs: if_id_flush (1, zero the IF/ID instr packet); id_exe_bubble (1, load a null ipacket into ID/EXE); stall_cycles (16, stall-cycle count).

Function
REQ-007 SHALL hold a registered FSM with states RUN, DMEM_WAIT, IMEM_WAIT, FLUSH; stall outputs are combinational from state plus current inputs.
REQ-008 SHALL define hazard = ex_valid & ex_load & ((id_sr1_used & id_sr1==ex_dr) | (id_sr2_used & id_sr2==ex_dr)).
REQ-009 SHALL, whenever dmem_req & ~dmem_resp, assert all four stall outputs in that cycle, deassert flush/bubble, and enter or remain in DMEM_WAIT.
REQ-010 SHALL, in DMEM_WAIT, return to RUN the cycle after dmem_resp=1; that response cycle asserts no stall.
REQ-011 SHALL, in RUN with no dmem wait, when imem_read & ~imem_resp, assert if_id_stall and id_exe_bubble only (downstream drains), and enter IMEM_WAIT until imem_resp.
REQ-012 SHALL, in RUN with no dmem/imem wait and hazard=1, assert if_id_stall and id_exe_bubble for exactly that cycle (one bubble); state stays RUN.
REQ-013 SHALL, on br_taken in RUN or IMEM_WAIT, assert if_id_flush and id_exe_bubble that cycle and the next (2-cycle counter in FLUSH), overriding load-use and imem-wait stalls.
REQ-014 SHALL latch br_taken arriving during DMEM_WAIT into a pending flag and perform the 2-cycle flush starting the cycle after dmem_resp.
REQ-015 SHALL give priority: dmem wait > branch flush > imem wait > load-use hazard.
REQ-016 SHALL never assert a stall of a later stage without stalling all earlier stages in the same cycle.

Reset
REQ-017 SHALL, when rst_n=0, asynchronously force state RUN, flush counter 0, pending flag 0, stall_cycles 0.
REQ-018 SHALL drive all stall, flush and bubble outputs 0 while rst_n=0, including reset asserted mid-DMEM_WAIT or mid-FLUSH.
REQ-019 SHALL start normal operation on the first clk edge after rst_n rises.

Configuration
REQ-020 SHALL, with STALL_PERF_CNT_EN defined, increment stall_cycles by 1 each cycle if_id_stall=1, saturating at 16'hFFFF.
REQ-021 SHALL, without STALL_PERF_CNT_EN, tie stall_cycles to 16'h0000 and instantiate no counter; all other behaviour identical.

Verification
REQ-022 SHALL cover load-use: ex_load=1, ex_valid=1, ex_dr=3, id_sr1=3, id_sr1_used=1 -> if_id_stall=1, id_exe_bubble=1 for one cycle, then 0.
REQ-023 SHALL cover dmem wait: dmem_req=1, dmem_resp=0 for 4 cycles then 1 -> all four stalls 1 for 4 cycles, 0 on response cycle.
REQ-024 SHALL cover branch during dmem wait: br_taken pulse in cycle 2 of a 3-cycle wait -> if_id_flush=1 for the 2 cycles after dmem_resp.
REQ-025 SHALL cover priority: hazard=1 and br_taken=1 together -> if_id_flush=1, id_exe_bubble=1, if_id_stall=0.
REQ-026 SHALL cover reset mid-wait: rst_n=0 in DMEM_WAIT -> all outputs 0 immediately, RUN after release.
REQ-027 SHALL cover counter (macro on): 5 load-use stalls plus a 3-cycle dmem wait -> stall_cycles=8; macro off -> stall_cycles=0.
